// File: rtl/fifo_pkg.sv
// Shared definitions for the watermark FIFO: depth helper and the status word layout
// used when the FIFO status is mapped into a CSR.
package fifo_pkg;

    // Bit positions of each status flag inside status_t (MSB first as declared).
    localparam int ST_UNDERFLOW    = 0;
    localparam int ST_OVERFLOW     = 1;
    localparam int ST_ALMOST_FULL  = 2;
    localparam int ST_ALMOST_EMPTY = 3;
    localparam int ST_FULL         = 4;
    localparam int ST_EMPTY        = 5;
    localparam int ST_WIDTH        = 6;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
        logic overflow;
        logic underflow;
    } status_t;

    function automatic int fifo_depth(input int w);
        return 32'sd1 << w;
    endfunction

endpackage

// File: rtl/fifo_regfile.sv
// Storage array for fifo_wm: synchronous write port, asynchronous read port.
module fifo_regfile
    import fifo_pkg::*;
#(
    parameter int B = 8,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         we,
    input  logic [W-1:0] waddr,
    input  logic [B-1:0] wdata,
    input  logic [W-1:0] raddr,
    output logic [B-1:0] rdata
);

    logic [B-1:0] mem_r [fifo_depth(W)];

    // Storage is intentionally unreset; contents are only meaningful once written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/fifo_wm.sv
// Synchronous show-ahead FIFO with occupancy count, watermarks, flush and sticky error flags.
// Optional high-water-mark output enabled by defining FIFO_HWM_EN.
module fifo_wm
    import fifo_pkg::*;
#(
    parameter int B      = 8,
    parameter int W      = 4,
    parameter int AF_LVL = 12,
    parameter int AE_LVL = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         clr_err,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    input  logic         rd,
    output logic [B-1:0] r_data,
    output logic         empty,
    output logic         full,
    output logic         almost_empty,
    output logic         almost_full,
    output logic [W:0]   count,
    output logic         overflow,
    output logic         underflow
`ifdef FIFO_HWM_EN
    ,
    output logic [W:0]   hwm
`endif
);

    localparam int         DEPTH_I = fifo_depth(W);
    localparam logic [W:0] DEPTH_C = DEPTH_I[W:0];
    localparam logic [W:0] AF_C    = AF_LVL[W:0];
    localparam logic [W:0] AE_C    = AE_LVL[W:0];

    localparam status_t STATUS_RST = '{
        empty:        1'b1,
        full:         1'b0,
        almost_empty: 1'b1,
        almost_full:  1'b0,
        overflow:     1'b0,
        underflow:    1'b0
    };

    logic [W-1:0] wr_ptr_r, wr_ptr_nxt_s;
    logic [W-1:0] rd_ptr_r, rd_ptr_nxt_s;
    logic [W:0]   count_r,  count_nxt_s;
    status_t      status_r, status_nxt_s;
    logic         wr_acc_s, rd_acc_s;
    logic         ovf_evt_s, udf_evt_s;

    // Accept decisions, pointer/count update and next status; flush masks all requests.
    always_comb begin
        wr_acc_s     = 1'b0;
        rd_acc_s     = 1'b0;
        ovf_evt_s    = 1'b0;
        udf_evt_s    = 1'b0;
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (flush) begin
            wr_ptr_nxt_s = {W{1'b0}};
            rd_ptr_nxt_s = {W{1'b0}};
            count_nxt_s  = {(W+1){1'b0}};
        end else begin
            wr_acc_s  = wr & (~status_r.full | rd);
            rd_acc_s  = rd & ~status_r.empty;
            ovf_evt_s = wr & status_r.full & ~rd;
            udf_evt_s = rd & status_r.empty;
            if (wr_acc_s) begin
                wr_ptr_nxt_s = wr_ptr_r + W'(1);
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (rd_acc_s) begin
                rd_ptr_nxt_s = rd_ptr_r + W'(1);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            if (wr_acc_s && !rd_acc_s) begin
                count_nxt_s = count_r + (W+1)'(1);
            end else if (rd_acc_s && !wr_acc_s) begin
                count_nxt_s = count_r - (W+1)'(1);
            end else begin
                count_nxt_s = count_r;
            end
        end

        status_nxt_s.empty        = (count_nxt_s == {(W+1){1'b0}});
        status_nxt_s.full         = (count_nxt_s == DEPTH_C);
        status_nxt_s.almost_empty = (count_nxt_s <= AE_C);
        status_nxt_s.almost_full  = (count_nxt_s >= AF_C);
        // A fresh error in the clearing cycle keeps the flag set.
        status_nxt_s.overflow     = ovf_evt_s | (status_r.overflow  & ~clr_err);
        status_nxt_s.underflow    = udf_evt_s | (status_r.underflow & ~clr_err);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {W{1'b0}};
            rd_ptr_r <= {W{1'b0}};
            count_r  <= {(W+1){1'b0}};
            status_r <= STATUS_RST;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            status_r <= status_nxt_s;
        end
    end

    fifo_regfile #(
        .B (B),
        .W (W)
    ) u_regfile (
        .clk   (clk),
        .we    (wr_acc_s),
        .waddr (wr_ptr_r),
        .wdata (w_data),
        .raddr (rd_ptr_r),
        .rdata (r_data)
    );

    assign count        = count_r;
    assign empty        = status_r.empty;
    assign full         = status_r.full;
    assign almost_empty = status_r.almost_empty;
    assign almost_full  = status_r.almost_full;
    assign overflow     = status_r.overflow;
    assign underflow    = status_r.underflow;

`ifdef FIFO_HWM_EN
    logic [W:0] hwm_r, hwm_nxt_s;

    // High-water mark restarts from the current level on flush or error clear.
    always_comb begin
        hwm_nxt_s = hwm_r;
        if (flush || clr_err) begin
            hwm_nxt_s = count_nxt_s;
        end else if (count_nxt_s > hwm_r) begin
            hwm_nxt_s = count_nxt_s;
        end else begin
            hwm_nxt_s = hwm_r;
        end
    end

    // High-water mark register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hwm_r <= {(W+1){1'b0}};
        end else begin
            hwm_r <= hwm_nxt_s;
        end
    end

    assign hwm = hwm_r;
`endif

endmodule

// File: tb/tb_fifo_wm.sv
// Directed self-checking bench for fifo_wm (B=8, W=4, AF_LVL=12, AE_LVL=2).
module tb_fifo_wm;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       flush, clr_err, wr, rd;
    logic [7:0] w_data;
    logic [7:0] r_data;
    logic       empty, full, almost_empty, almost_full, overflow, underflow;
    logic [4:0] count;
`ifdef FIFO_HWM_EN
    logic [4:0] hwm;
`endif

    int checks   = 0;
    int failures = 0;
    logic [7:0] q[$];
    logic [7:0] exp_head;

    fifo_wm #(.B(8), .W(4), .AF_LVL(12), .AE_LVL(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush        (flush),
        .clr_err      (clr_err),
        .wr           (wr),
        .w_data       (w_data),
        .rd           (rd),
        .r_data       (r_data),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
`ifdef FIFO_HWM_EN
        ,
        .hwm          (hwm)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, int'(count), 0);
        check({tag, "_empty"}, int'(empty), 1);
        check({tag, "_full"}, int'(full), 0);
        check({tag, "_ae"}, int'(almost_empty), 1);
        check({tag, "_af"}, int'(almost_full), 0);
        check({tag, "_ovf"}, int'(overflow), 0);
        check({tag, "_udf"}, int'(underflow), 0);
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; clr_err = 1'b0; wr = 1'b0; rd = 1'b0; w_data = 8'h00;
        #12;
        check_reset_state("rst");
        reset_n = 1'b1;

        // 1: fill 0x01..0x10, then drain in order
        for (int i = 1; i <= 16; i++) begin
            wr = 1'b1; w_data = 8'(i);
            step();
            check("t1_count", int'(count), i);
            check("t1_ae", int'(almost_empty), (i <= 2) ? 1 : 0);
            check("t1_af", int'(almost_full), (i >= 12) ? 1 : 0);
            check("t1_full", int'(full), (i == 16) ? 1 : 0);
            check("t1_empty", int'(empty), 0);
            check("t1_head", int'(r_data), 1);
        end
        wr = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            check("t1_rdata", int'(r_data), i);
            rd = 1'b1;
            step();
            check("t1_rcount", int'(count), 16 - i);
        end
        rd = 1'b0;
        check("t1_empty_end", int'(empty), 1);
        check("t1_ae_end", int'(almost_empty), 1);

        // 2: overflow on write while full
        for (int i = 1; i <= 16; i++) begin
            wr = 1'b1; w_data = 8'(i);
            step();
        end
        w_data = 8'hAA;
        step();
        wr = 1'b0;
        check("t2_ovf", int'(overflow), 1);
        check("t2_count", int'(count), 16);
        check("t2_head", int'(r_data), 8'h01);
        check("t2_udf", int'(underflow), 0);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("t2_ovf_clr", int'(overflow), 0);

        // 3: simultaneous wr&rd while full
        wr = 1'b1; rd = 1'b1; w_data = 8'h55;
        step();
        wr = 1'b0; rd = 1'b0;
        check("t3_count", int'(count), 16);
        check("t3_full", int'(full), 1);
        check("t3_ovf", int'(overflow), 0);
        check("t3_head", int'(r_data), 8'h02);
        for (int i = 2; i <= 17; i++) begin
            check("t3_rdata", int'(r_data), (i == 17) ? 8'h55 : i);
            rd = 1'b1;
            step();
        end
        rd = 1'b0;
        check("t3_empty", int'(empty), 1);

        // 4: simultaneous wr&rd while empty
        wr = 1'b1; rd = 1'b1; w_data = 8'h33;
        step();
        wr = 1'b0; rd = 1'b0;
        check("t4_count", int'(count), 1);
        check("t4_rdata", int'(r_data), 8'h33);
        check("t4_udf", int'(underflow), 1);
        check("t4_empty", int'(empty), 0);
        rd = 1'b1;
        step();
        rd = 1'b0;
        check("t4_drain", int'(count), 0);

        // 5a: underflow then flush with pending wr/rd keeps flags and stores nothing
        rd = 1'b1;
        step();
        rd = 1'b0;
        check("t5_udf_pre", int'(underflow), 1);
        for (int i = 0; i < 7; i++) begin
            wr = 1'b1; w_data = 8'(8'h40 + i);
            step();
        end
        wr = 1'b0;
        check("t5_count7", int'(count), 7);
        flush = 1'b1; wr = 1'b1; rd = 1'b1; w_data = 8'h99;
        step();
        flush = 1'b0; wr = 1'b0; rd = 1'b0;
        check("t5_fl_count", int'(count), 0);
        check("t5_fl_empty", int'(empty), 1);
        check("t5_fl_ae", int'(almost_empty), 1);
        check("t5_fl_udf", int'(underflow), 1);
        check("t5_fl_ovf", int'(overflow), 0);
        wr = 1'b1; w_data = 8'h77;
        step();
        wr = 1'b0;
        check("t5_post_count", int'(count), 1);
        check("t5_post_head", int'(r_data), 8'h77);
        rd = 1'b1; clr_err = 1'b1;
        step();
        rd = 1'b0; clr_err = 1'b0;
        check("t5_clr_udf", int'(underflow), 0);

        // 5b: interleaved traffic across pointer wrap, checked against a queue model
        q.delete();
        for (int i = 0; i < 3; i++) begin
            wr = 1'b1; w_data = 8'(8'hC0 + i);
            q.push_back(w_data);
            step();
        end
        wr = 1'b0;
        for (int k = 0; k < 40; k++) begin
            wr = (k % 3 != 1);
            rd = (k % 3 != 0);
            w_data = 8'(k * 7 + 3);
            exp_head = q[0];
            check("t5_wrap_head", int'(r_data), int'(exp_head));
            if (rd) void'(q.pop_front());
            if (wr) q.push_back(w_data);
            step();
            check("t5_wrap_count", int'(count), q.size());
        end
        wr = 1'b0; rd = 1'b0;
        check("t5_wrap_udf", int'(underflow), 0);
        check("t5_wrap_ovf", int'(overflow), 0);

        // 6: async reset mid-burst at count 9
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr = 1'b1; w_data = 8'(8'hE0 + i);
            step();
        end
        check("t6_count9", int'(count), 9);
`ifdef FIFO_HWM_EN
        check("t6_hwm9", int'(hwm), 9);
`endif
        reset_n = 1'b0;
        #1;
        check_reset_state("t6");
`ifdef FIFO_HWM_EN
        check("t6_hwm0", int'(hwm), 0);
`endif
        wr = 1'b0;
        #2;
        reset_n = 1'b1;
        step();
        check("t6_after_count", int'(count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
